// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter with a small holding FIFO.
//
// Bytes enter via a valid/ready handshake into a 2**FIFO_AW entry FIFO.
// Each byte is sent LSB-first as: start bit, 8 data bits, optional parity
// bit, then 1 or 2 stop bits. Each bit lasts 16 pulses of tick_16x.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   tick_16x   one-clk enable pulse at 16x the baud rate
//   lcr        {stop_bits, parity_type, parity_en}; latched at frame start
//   tx_data    byte to transmit
//   tx_valid   tx_data is valid
//   tx_ready   FIFO can accept a byte (not full)
//   tx         serial line, idle high
//   tx_busy    a frame is in progress
//   tx_done    one-clk pulse at the end of the last stop bit
//   fifo_count bytes held in the FIFO (the shifter is not counted)
module uart_tx #(
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_16x,
    input  logic [2:0]       lcr,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // parity_type = 1 selects even parity (bit equals XOR of data).
    function automatic logic parity_bit(input logic [7:0] data, input logic even);
        return even ? (^data) : (~^data);
    endfunction

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_next_s;
    logic               ready_r;

    state_t             state_r;
    logic [7:0]         shift_r;
    logic [2:0]         cfg_r;
    logic [3:0]         tick_cnt_r;
    logic [2:0]         bit_idx_r;
    logic [2:0]         next_idx_s;
    logic               stop_cnt_r;
    logic               tx_r;
    logic               busy_r;
    logic               done_r;

    logic               push_s;
    logic               pop_s;
    logic               bit_end_s;

    // ready_r reflects the count at the start of the cycle, so a full FIFO
    // never accepts a push even when a pop happens in the same cycle.
    assign push_s     = tx_valid && ready_r;
    // Pop only looks at the registered count, so a push into an empty FIFO
    // becomes visible to the FSM one cycle later.
    assign pop_s      = (state_r == ST_IDLE) && (count_r != '0);
    assign bit_end_s  = tick_16x && (tick_cnt_r == 4'd15);
    assign next_idx_s = bit_idx_r + 3'd1;

    assign tx_ready   = ready_r;
    assign tx         = tx_r;
    assign tx_busy    = busy_r;
    assign tx_done    = done_r;
    assign fifo_count = count_r;

    // Next FIFO occupancy from this cycle's push and pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{FIFO_AW{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != DEPTH_C);
        end
    end

    // Frame state machine; tx is updated on the same edge as the state so
    // it always shows the bit belonging to the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            cfg_r      <= 3'b000;
            tick_cnt_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // The counter wraps 15 -> 0 by itself on the bit-ending tick.
            if (tick_16x && (state_r != ST_IDLE)) begin
                tick_cnt_r <= tick_cnt_r + 4'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r    <= mem_r[rd_ptr_r];
                        cfg_r      <= lcr;
                        tick_cnt_r <= 4'd0;
                        bit_idx_r  <= 3'd0;
                        stop_cnt_r <= 1'b0;
                        state_r    <= ST_START;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == 3'd7) begin
                            if (cfg_r[0]) begin
                                state_r <= ST_PARITY;
                                tx_r    <= parity_bit(shift_r, cfg_r[1]);
                            end else begin
                                state_r    <= ST_STOP;
                                stop_cnt_r <= 1'b0;
                                tx_r       <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= next_idx_s;
                            tx_r      <= shift_r[next_idx_s];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= ST_STOP;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        // With two stop bits, the first bit end only advances
                        // the stop counter.
                        if (cfg_r[2] && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Stimulus pushes the expected
// byte and frame format into a queue; a monitor decodes the tx line at
// bit centres, times each frame in ticks and compares on every tx_done.
module tb_uart_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_16x = 1'b0;
    logic [2:0] lcr      = 3'b000;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    typedef struct {
        logic [7:0] data;
        logic [2:0] cfg;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   done_cnt    = 0;
    int   tick_period = 0;
    bit   in_reset    = 1'b0;

    uart_tx #(.FIFO_AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_16x   (tick_16x),
        .lcr        (lcr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Tick generator: 0 = no ticks, N = one tick every N clks.
    initial begin
        int tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt++;
            tick_16x = (tick_period != 0) && ((tcnt % tick_period) == 0);
        end
    end

    // Expected frame bits: start, data LSB first, parity, stop bit(s).
    function automatic void build_frame(input exp_t e, output logic [11:0] bits, output int n);
        int ones = 0;
        bits = 12'h000;
        for (int i = 0; i < 8; i++) begin
            bits[i + 1] = e.data[i];
            if (e.data[i]) ones++;
        end
        n = 9;
        if (e.cfg[0]) begin
            // even parity makes the total count of ones even
            bits[n] = e.cfg[1] ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (e.cfg[2]) begin
            bits[n] = 1'b1;
            n++;
        end
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        bit          active     = 1'b0;
        bit          busy_ok    = 1'b1;
        logic        prev_tx    = 1'b1;
        int          ticks      = 0;
        int          since_done = 100;
        logic [11:0] got        = 12'h000;
        logic [11:0] want;
        int          n;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            if (since_done < 100) since_done++;
            if (tx_done === 1'b1) done_cnt++;
            if (active) begin
                if (in_reset && (tx_busy === 1'b0)) begin
                    check("done_in_reset", {31'd0, tx_done}, 32'd0);
                    active = 1'b0;
                end else begin
                    if (tick_16x) begin
                        ticks++;
                        if (((ticks % 16) == 8) && ((ticks / 16) < 12)) got[ticks / 16] = tx;
                    end
                    if ((tx_busy !== 1'b1) && (tx_done !== 1'b1)) busy_ok = 1'b0;
                    if (tx_done === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            build_frame(e, want, n);
                            check("frame_len", ticks, 16 * n);
                            check("frame_bits", {20'd0, got}, {20'd0, want});
                            check("busy_in_frame", {31'd0, busy_ok}, 32'd1);
                            check("busy_after_done", {31'd0, tx_busy}, 32'd0);
                        end
                        active     = 1'b0;
                        since_done = 0;
                    end else if (ticks > 200) begin
                        check("frame_timeout", ticks, 32'd192);
                        active = 1'b0;
                    end
                end
            end else begin
                if (tx_done === 1'b1) check("done_outside_frame", 32'd1, 32'd0);
                if ((prev_tx === 1'b1) && (tx === 1'b0)) begin
                    active  = 1'b1;
                    busy_ok = 1'b1;
                    ticks   = 0;
                    got     = 12'h000;
                    if ((exp_q.size() > 0) && exp_q[0].b2b) check("idle_gap", since_done, 32'd1);
                end
            end
            prev_tx = tx;
        end
    end

    // Caller must be at a negedge; returns at the next negedge.
    task automatic push(input logic [7:0] d, input bit b2b, input bit accept);
        if (accept) exp_q.push_back('{data: d, cfg: lcr, b2b: b2b});
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while (((exp_q.size() != 0) || (tx_busy !== 1'b0)) && (cyc < budget)) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_timeout", {31'd0, (cyc < budget)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] lb [3] = '{8'h00, 8'hFF, 8'h3C};
        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x55, no parity, 1 stop, tick every 4 clks
        tick_period = 4;
        lcr = 3'b000;
        push(8'h55, 1'b0, 1'b1);
        drain(4000);

        // 0xA5 with even then odd parity
        lcr = 3'b011;
        push(8'hA5, 1'b0, 1'b1);
        drain(4000);
        lcr = 3'b001;
        push(8'hA5, 1'b0, 1'b1);
        drain(4000);

        // 0x00 with two stop bits
        lcr = 3'b100;
        push(8'h00, 1'b0, 1'b1);
        drain(4000);

        // ticks held off: fill shifter + FIFO, sixth byte refused
        tick_period = 0;
        lcr = 3'b000;
        @(negedge clk);
        push(8'h11, 1'b0, 1'b1);
        push(8'h22, 1'b1, 1'b1);
        push(8'h33, 1'b1, 1'b1);
        push(8'h44, 1'b1, 1'b1);
        push(8'h55, 1'b1, 1'b1);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        push(8'h66, 1'b1, 1'b0);
        check("full_count_after_reject", {29'd0, fifo_count}, 32'd4);
        tick_period = 1;
        drain(4000);

        // every lcr value with three bytes, continuous ticks
        for (int c = 0; c < 8; c++) begin
            lcr = c[2:0];
            for (int j = 0; j < 3; j++) push(lb[j], (j > 0), 1'b1);
            drain(4000);
        end

        // reset mid-DATA with two bytes queued
        lcr = 3'b000;
        push(8'hA1, 1'b0, 1'b1);
        push(8'hB2, 1'b1, 1'b1);
        push(8'hC3, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        in_reset = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_count", {29'd0, fifo_count}, 32'd0);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        push(8'h5A, 1'b0, 1'b1);
        drain(4000);

        // 1+1+1+1+5+24+1 completed frames
        check("frame_count", done_cnt, 32'd34);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
